// File: rtl/ima_adpcm_dec_seq.sv
// Block sequencer for the IMA ADPCM decoder: parses each block header into a
// decoder state load, then streams payload nibbles (low first) paced by decReady.
module ima_adpcm_dec_seq #(
  parameter int unsigned BLOCK_BYTES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  input  logic        inFlush,
  output logic [3:0]  decPCM,
  output logic        decValid,
  input  logic        decReady,
  output logic [15:0] decPredictSamp,
  output logic [6:0]  decStepIndex,
  output logic        decStateLoad,
  output logic        blockStart,
  output logic        blockDone,
  output logic        hdrError
);

  localparam int unsigned CNT_W    = $clog2(BLOCK_BYTES);
  localparam int unsigned LAST_IDX = BLOCK_BYTES - 5;
  localparam logic [7:0]  MAX_STEP = 8'd88;

  typedef enum logic [2:0] {HDR0, HDR1, HDR2, HDR3, LOAD, SETTLE, DATA} stateT;

  stateT            state;
  stateT            nextState;
  logic [7:0]       dataByte;
  logic             dataFull;
  logic             phaseHi;
  logic [CNT_W-1:0] payCnt;
  logic             stepErr;

  logic accept;
  logic issue;
  logic issueHi;
  logic lastIssue;

  assign accept    = inValid & inReady;
  assign issue     = (state == DATA) & dataFull & decReady & ~inFlush;
  assign issueHi   = issue & phaseHi;
  assign lastIssue = issueHi & (payCnt == CNT_W'(LAST_IDX));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= HDR0;
    else        state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    if (inFlush) begin
      nextState = HDR0;
    end else begin
      case (state)
        HDR0:    if (accept) nextState = HDR1;
        HDR1:    if (accept) nextState = HDR2;
        HDR2:    if (accept) nextState = HDR3;
        HDR3:    if (accept) nextState = LOAD;
        LOAD:    nextState = SETTLE;
        SETTLE:  nextState = DATA;
        DATA:    if (lastIssue) nextState = HDR0;
        default: nextState = HDR0;
      endcase
    end
  end

  // Output logic; a flush cycle silences every strobe and blocks input
  always_comb begin
    inReady      = 1'b0;
    decValid     = 1'b0;
    decPCM       = 4'd0;
    decStateLoad = 1'b0;
    blockStart   = 1'b0;
    blockDone    = 1'b0;
    hdrError     = 1'b0;
    if (!inFlush) begin
      case (state)
        HDR0, HDR1, HDR2, HDR3: inReady = 1'b1;
        LOAD: begin
          decStateLoad = 1'b1;
          blockStart   = 1'b1;
          hdrError     = stepErr;
        end
        DATA: begin
          inReady   = (~dataFull | (phaseHi & dataFull & decReady)) & ~lastIssue;
          decValid  = issue;
          blockDone = lastIssue;
          if (issue) decPCM = phaseHi ? dataByte[7:4] : dataByte[3:0];
        end
        default: ;
      endcase
    end
  end

  // Header capture, payload buffer, nibble phase and payload counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      decPredictSamp <= 16'd0;
      decStepIndex   <= 7'd0;
      stepErr        <= 1'b0;
      dataByte       <= 8'd0;
      dataFull       <= 1'b0;
      phaseHi        <= 1'b0;
      payCnt         <= '0;
    end else if (inFlush) begin
      dataFull <= 1'b0;
      phaseHi  <= 1'b0;
      payCnt   <= '0;
    end else begin
      case (state)
        HDR0: if (accept) decPredictSamp[7:0]  <= inData;
        HDR1: if (accept) decPredictSamp[15:8] <= inData;
        HDR2: if (accept) begin
          decStepIndex <= (inData > MAX_STEP) ? 7'd88 : inData[6:0];
          stepErr      <= (inData > MAX_STEP);
        end
        SETTLE: begin
          dataFull <= 1'b0;
          phaseHi  <= 1'b0;
          payCnt   <= '0;
        end
        DATA: begin
          if (issue) begin
            phaseHi <= ~phaseHi;
            if (phaseHi) payCnt <= payCnt + CNT_W'(1);
          end
          // A byte landing on the HI issue cycle refills the buffer seamlessly
          if (accept) begin
            dataByte <= inData;
            dataFull <= 1'b1;
          end else if (issueHi) begin
            dataFull <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ima_adpcm_dec_seq.sv
// Scoreboard bench for ima_adpcm_dec_seq: a byte-stream block parser model
// predicts loads and nibbles; a negedge monitor compares whatever the DUT emits.
module tb_ima_adpcm_dec_seq;

  localparam int unsigned BB = 8;

  logic        clock;
  logic        reset;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic        inFlush;
  logic [3:0]  decPCM;
  logic        decValid;
  logic        decReady;
  logic [15:0] decPredictSamp;
  logic [6:0]  decStepIndex;
  logic        decStateLoad;
  logic        blockStart;
  logic        blockDone;
  logic        hdrError;

  int checks = 0;
  int failures = 0;

  logic [4:0]  nibQ[$];
  logic [23:0] loadQ[$];
  int          strobeCyc[$];
  logic [4:0]  expN;
  logic [23:0] expL;

  int unsigned modelPos = 0;
  logic [15:0] mPred = 16'd0;
  logic [6:0]  mStep = 7'd0;
  logic        mErr = 1'b0;

  int cyc = 0;
  int strobeCount = 0;
  int loadCount = 0;
  int doneCount = 0;
  bit holdLow = 1'b0;
  int readyMode = 0;
  int unsigned gapMax = 0;

  ima_adpcm_dec_seq #(.BLOCK_BYTES(BB)) dut (
    .clock(clock), .reset(reset),
    .inData(inData), .inValid(inValid), .inReady(inReady), .inFlush(inFlush),
    .decPCM(decPCM), .decValid(decValid), .decReady(decReady),
    .decPredictSamp(decPredictSamp), .decStepIndex(decStepIndex),
    .decStateLoad(decStateLoad), .blockStart(blockStart),
    .blockDone(blockDone), .hdrError(hdrError)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: interpret accepted bytes by their position within a block
  task automatic modelAccept(input logic [7:0] b);
    case (modelPos)
      0: mPred[7:0] = b;
      1: mPred[15:8] = b;
      2: begin
        mErr  = (b > 8'd88);
        mStep = mErr ? 7'd88 : b[6:0];
      end
      3: loadQ.push_back({mErr, mStep, mPred});
      default: begin
        nibQ.push_back({1'b0, b[3:0]});
        nibQ.push_back({(modelPos == BB - 1), b[7:4]});
      end
    endcase
    modelPos = (modelPos == BB - 1) ? 0 : modelPos + 1;
  endtask

  // Decoder ready generator: 0 = always, 1 = random, 2 = low one cycle after a strobe
  initial begin
    logic lastV;
    decReady = 1'b1;
    lastV = 1'b0;
    forever begin
      @(negedge clock);
      lastV = decValid;
      @(posedge clock);
      #1;
      if (holdLow)             decReady = 1'b0;
      else if (readyMode == 1) decReady = ($urandom_range(0, 2) != 0);
      else if (readyMode == 2) decReady = ~lastV;
      else                     decReady = 1'b1;
    end
  end

  // Monitor
  always @(negedge clock) begin
    if (reset) begin
      if (decValid) begin
        strobeCount++;
        strobeCyc.push_back(cyc);
        check("strobe_while_not_ready", 32'(decReady), 32'd1);
        check("strobe_expected", 32'(nibQ.size() != 0), 32'd1);
        if (nibQ.size() != 0) begin
          expN = nibQ.pop_front();
          check("nibble", 32'(decPCM), 32'(expN[3:0]));
          check("block_done", 32'(blockDone), 32'(expN[4]));
        end
        if (blockDone) doneCount++;
      end else begin
        check("done_without_strobe", 32'(blockDone), 32'd0);
      end
      check("block_start_vs_load", 32'(blockStart), 32'(decStateLoad));
      if (decStateLoad) begin
        loadCount++;
        check("load_expected", 32'(loadQ.size() != 0), 32'd1);
        if (loadQ.size() != 0) begin
          expL = loadQ.pop_front();
          check("predict", 32'(decPredictSamp), 32'(expL[15:0]));
          check("step_index", 32'(decStepIndex), 32'(expL[22:16]));
          check("hdr_error", 32'(hdrError), 32'(expL[23]));
        end
      end else begin
        check("hdr_error_without_load", 32'(hdrError), 32'd0);
      end
    end
  end

  task automatic sendByte(input logic [7:0] b);
    int g;
    logic acc;
    if (gapMax > 0) begin
      inValid = 1'b0;
      repeat ($urandom_range(0, gapMax)) begin
        @(posedge clock);
        #1;
      end
    end
    inData  = b;
    inValid = 1'b1;
    g = 0;
    acc = 1'b0;
    while (!acc && g < 300) begin
      @(negedge clock);
      acc = inReady;
      @(posedge clock);
      #1;
      g++;
    end
    check("byte_accepted", 32'(acc), 32'd1);
    inValid = 1'b0;
    if (acc) modelAccept(b);
  endtask

  task automatic sendBlock(input logic [15:0] p, input logic [7:0] s);
    sendByte(p[7:0]);
    sendByte(p[15:8]);
    sendByte(s);
    sendByte(8'($urandom));
    for (int i = 4; i < int'(BB); i++) sendByte(8'($urandom));
  endtask

  task automatic waitDrain();
    int g;
    g = 0;
    while ((nibQ.size() != 0 || loadQ.size() != 0) && g < 2000) begin
      @(posedge clock);
      #1;
      g++;
    end
    check("drain", 32'(g < 2000), 32'd1);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int l0, d0, s0;
    reset   = 1'b0;
    inData  = 8'd0;
    inValid = 1'b0;
    inFlush = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 32'(inReady), 32'd1);
    check("rst_dec_valid", 32'(decValid), 32'd0);
    check("rst_dec_pcm", 32'(decPCM), 32'd0);
    check("rst_state_load", 32'(decStateLoad), 32'd0);
    check("rst_block_done", 32'(blockDone), 32'd0);
    check("rst_hdr_error", 32'(hdrError), 32'd0);
    check("rst_predict", 32'(decPredictSamp), 32'd0);
    check("rst_step", 32'(decStepIndex), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Reference block: nibbles 7,A,C,3,1,0,F,0 two cycles apart
    readyMode = 2;
    gapMax = 0;
    strobeCyc.delete();
    sendByte(8'h34); sendByte(8'h12); sendByte(8'h05); sendByte(8'h00);
    sendByte(8'hA7); sendByte(8'h3C); sendByte(8'h01); sendByte(8'h0F);
    waitDrain();
    check("t1_strobe_count", 32'(strobeCyc.size()), 32'd8);
    for (int i = 1; i < strobeCyc.size(); i++)
      check("t1_strobe_spacing", 32'(strobeCyc[i] - strobeCyc[i-1]), 32'd2);
    check("t1_predict_held", 32'(decPredictSamp), 32'h1234);
    check("t1_step_held", 32'(decStepIndex), 32'd5);

    // Step index clamping and error boundary
    readyMode = 1;
    sendBlock(16'h8001, 8'h64);
    sendBlock(16'h7FFF, 8'hFF);
    sendBlock(16'h0F0F, 8'd88);
    sendBlock(16'hF0F0, 8'd89);
    sendBlock(16'h5A5A, 8'h80);
    waitDrain();
    check("clamp_step_held", 32'(decStepIndex), 32'd88);

    // Decoder stall with a full buffer
    readyMode = 0;
    holdLow = 1'b1;
    sendByte(8'hEF); sendByte(8'hBE); sendByte(8'h10); sendByte(8'h00);
    sendByte(8'h96);
    fork
      begin
        repeat (10) begin
          @(negedge clock);
          check("stall_in_ready", 32'(inReady), 32'd0);
          check("stall_no_strobe", 32'(decValid), 32'd0);
        end
        @(posedge clock);
        #1;
        holdLow = 1'b0;
      end
      sendByte(8'h5D);
    join
    sendByte(8'hC3);
    sendByte(8'h2E);
    waitDrain();

    // Flush after two payload nibbles
    sendByte(8'h21); sendByte(8'h43); sendByte(8'h07); sendByte(8'h00);
    sendByte(8'hB4);
    waitDrain();
    inFlush = 1'b1;
    @(negedge clock);
    check("flush_in_ready", 32'(inReady), 32'd0);
    check("flush_dec_valid", 32'(decValid), 32'd0);
    check("flush_state_load", 32'(decStateLoad), 32'd0);
    check("flush_block_done", 32'(blockDone), 32'd0);
    @(posedge clock);
    #1;
    inFlush = 1'b0;
    modelPos = 0;
    check("flush_predict_kept", 32'(decPredictSamp), 32'h4321);
    check("flush_step_kept", 32'(decStepIndex), 32'd7);
    repeat (6) begin
      @(posedge clock);
      #1;
    end
    sendBlock(16'h1357, 8'd20);
    waitDrain();
    check("post_flush_predict", 32'(decPredictSamp), 32'h1357);
    check("post_flush_step", 32'(decStepIndex), 32'd20);

    // Two back-to-back blocks, input held valid
    readyMode = 2;
    l0 = loadCount;
    d0 = doneCount;
    s0 = strobeCount;
    sendBlock(16'hAAAA, 8'd3);
    sendBlock(16'h5555, 8'd60);
    waitDrain();
    check("b2b_loads", 32'(loadCount - l0), 32'd2);
    check("b2b_dones", 32'(doneCount - d0), 32'd2);
    check("b2b_strobes", 32'(strobeCount - s0), 32'(2 * (BB - 4) * 2));

    // Randomized blocks with input gaps and random decoder ready
    readyMode = 1;
    gapMax = 2;
    repeat (25) sendBlock(16'($urandom), 8'($urandom));
    waitDrain();
    gapMax = 0;

    // Asynchronous reset in the middle of a payload byte
    readyMode = 0;
    holdLow = 1'b1;
    sendByte(8'h99); sendByte(8'h88); sendByte(8'h30); sendByte(8'h00);
    sendByte(8'h7E);
    #2;
    reset = 1'b0;
    #1;
    check("arst_dec_valid", 32'(decValid), 32'd0);
    check("arst_state_load", 32'(decStateLoad), 32'd0);
    check("arst_dec_pcm", 32'(decPCM), 32'd0);
    check("arst_predict", 32'(decPredictSamp), 32'd0);
    check("arst_step", 32'(decStepIndex), 32'd0);
    check("arst_in_ready", 32'(inReady), 32'd1);
    nibQ.delete();
    loadQ.delete();
    modelPos = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    holdLow = 1'b0;
    @(posedge clock);
    #1;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    sendBlock(16'h2468, 8'd44);
    waitDrain();

    check("final_nibble_queue_empty", 32'(nibQ.size()), 32'd0);
    check("final_load_queue_empty", 32'(loadQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
